// File: rtl/alu_cmd_pkg.sv
// Shared encodings, state type and data width for the ALU command controller.
// The overflow helper is used when ALU_CMD_CTRL_OVF_EN is defined.
package alu_cmd_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SLT  = 3'b100,
        OP_NOR  = 3'b101,
        OP_NAND = 3'b110,
        OP_ILL  = 3'b111
    } cmd_op_e;

    typedef enum logic [1:0] {
        ALU_AND  = 2'b00,
        ALU_OR   = 2'b01,
        ALU_ADD  = 2'b10,
        ALU_LESS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SLT2,
        RESP
    } state_e;

    // Signed overflow: both addends share a sign that the sum does not.
    function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] sum);
        return (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit MIPS-style ALU driven by the controller's alu_* outputs.
// cout is always the raw carry of the internal adder, whatever the operation.
module alu8
    import alu_cmd_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_invert,
    input  logic              b_invert,
    input  logic              cin,
    input  logic              less,
    input  logic [1:0]        operation,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    logic [DATA_W-1:0] aa;
    logic [DATA_W-1:0] bb;
    logic [DATA_W:0]   sum;

    assign aa   = a ^ {DATA_W{a_invert}};
    assign bb   = b ^ {DATA_W{b_invert}};
    assign sum  = {1'b0, aa} + {1'b0, bb} + {{DATA_W{1'b0}}, cin};
    assign cout = sum[DATA_W];

    always_comb begin
        result = '0;
        case (operation)
            ALU_AND: result = aa & bb;
            ALU_OR:  result = aa | bb;
            ALU_ADD: result = sum[DATA_W-1:0];
            default: result = {{(DATA_W-1){1'b0}}, less};
        endcase
    end

endmodule

// File: rtl/alu_cmd_decode.sv
// Combinational command decode: maps a cmd_op (and cmd_cin) onto the
// ALU control bits used for the first ALU pass.
module alu_cmd_decode
    import alu_cmd_pkg::*;
(
    input  logic [2:0] cmd_op,
    input  logic       cmd_cin,
    output logic       a_invert,
    output logic       b_invert,
    output logic       alu_cin,
    output logic [1:0] operation,
    output logic       is_arith,
    output logic       is_slt,
    output logic       illegal
);

    // SLT runs its first pass exactly like SUB; the less phase is set up later.
    always_comb begin
        a_invert  = 1'b0;
        b_invert  = 1'b0;
        alu_cin   = 1'b0;
        operation = ALU_AND;
        is_arith  = 1'b0;
        is_slt    = 1'b0;
        illegal   = 1'b0;
        case (cmd_op)
            OP_AND: begin
                operation = ALU_AND;
            end
            OP_OR: begin
                operation = ALU_OR;
            end
            OP_ADD: begin
                alu_cin   = cmd_cin;
                operation = ALU_ADD;
                is_arith  = 1'b1;
            end
            OP_SUB: begin
                b_invert  = 1'b1;
                alu_cin   = 1'b1;
                operation = ALU_ADD;
                is_arith  = 1'b1;
            end
            OP_SLT: begin
                b_invert  = 1'b1;
                alu_cin   = 1'b1;
                operation = ALU_ADD;
                is_slt    = 1'b1;
            end
            OP_NOR: begin
                a_invert  = 1'b1;
                b_invert  = 1'b1;
                operation = ALU_AND;
            end
            OP_NAND: begin
                a_invert  = 1'b1;
                b_invert  = 1'b1;
                operation = ALU_OR;
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command/response controller sequencing an external ALU through IDLE, EXEC, SLT2, RESP.
// Define ALU_CMD_CTRL_OVF_EN to produce rsp_ovf and overflow-corrected SLT; otherwise ovf is 0.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_cin,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic              alu_less,
    output logic              alu_a_invert,
    output logic              alu_b_invert,
    output logic              alu_cin,
    output logic [1:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic [7:0]        rsp_count
);

    state_e state;
    state_e state_next;

    logic       dec_a_invert;
    logic       dec_b_invert;
    logic       dec_cin;
    logic [1:0] dec_operation;
    logic       dec_arith;
    logic       dec_slt;
    logic       dec_illegal;

    logic op_arith;
    logic op_slt;
    logic hs;
    logic phase1_ovf;
    logic slt_set;

    alu_cmd_decode u_decode (
        .cmd_op    (cmd_op),
        .cmd_cin   (cmd_cin),
        .a_invert  (dec_a_invert),
        .b_invert  (dec_b_invert),
        .alu_cin   (dec_cin),
        .operation (dec_operation),
        .is_arith  (dec_arith),
        .is_slt    (dec_slt),
        .illegal   (dec_illegal)
    );

    assign hs = cmd_valid && cmd_ready;

    // Overflow is judged on the operands the ALU actually adds, i.e. after inversion.
`ifdef ALU_CMD_CTRL_OVF_EN
    logic [DATA_W-1:0] eff_a;
    logic [DATA_W-1:0] eff_b;
    assign eff_a      = alu_src1 ^ {DATA_W{alu_a_invert}};
    assign eff_b      = alu_src2 ^ {DATA_W{alu_b_invert}};
    assign phase1_ovf = add_ovf(eff_a, eff_b, alu_result);
`else
    assign phase1_ovf = 1'b0;
`endif

    assign slt_set = alu_result[DATA_W-1] ^ phase1_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    state_next = dec_illegal ? RESP : EXEC;
                end
            end
            EXEC: begin
                state_next = op_slt ? SLT2 : RESP;
            end
            SLT2: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // An illegal op never touches the alu_* registers, so the ALU keeps its last setup.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src1      <= '0;
            alu_src2      <= '0;
            alu_less      <= 1'b0;
            alu_a_invert  <= 1'b0;
            alu_b_invert  <= 1'b0;
            alu_cin       <= 1'b0;
            alu_operation <= ALU_AND;
            rsp_result    <= '0;
            rsp_cout      <= 1'b0;
            rsp_ovf       <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_count     <= 8'd0;
            op_arith      <= 1'b0;
            op_slt        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        if (dec_illegal) begin
                            rsp_result <= '0;
                            rsp_cout   <= 1'b0;
                            rsp_ovf    <= 1'b0;
                            rsp_err    <= 1'b1;
                        end else begin
                            alu_src1      <= cmd_a;
                            alu_src2      <= cmd_b;
                            alu_less      <= 1'b0;
                            alu_a_invert  <= dec_a_invert;
                            alu_b_invert  <= dec_b_invert;
                            alu_cin       <= dec_cin;
                            alu_operation <= dec_operation;
                            op_arith      <= dec_arith;
                            op_slt        <= dec_slt;
                            rsp_err       <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_cout   <= alu_cout;
                    rsp_ovf    <= op_arith & phase1_ovf;
                    if (op_slt) begin
                        alu_less      <= slt_set;
                        alu_operation <= ALU_LESS;
                        alu_b_invert  <= 1'b1;
                        alu_cin       <= 1'b1;
                    end
                end
                SLT2: begin
                    rsp_result <= alu_result;
                    rsp_cout   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_count <= rsp_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl driving a real alu8; expectations come from
// a plain-arithmetic model of each command. Honours ALU_CMD_CTRL_OVF_EN if defined.
module tb_alu_cmd_ctrl;

`ifdef ALU_CMD_CTRL_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_cin;
    logic [7:0] alu_src1;
    logic [7:0] alu_src2;
    logic       alu_less;
    logic       alu_a_invert;
    logic       alu_b_invert;
    logic       alu_cin;
    logic [1:0] alu_operation;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_cout;
    logic       rsp_ovf;
    logic       rsp_err;
    logic [7:0] rsp_count;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_count = 8'd0;

    alu_cmd_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_cin       (cmd_cin),
        .alu_src1      (alu_src1),
        .alu_src2      (alu_src2),
        .alu_less      (alu_less),
        .alu_a_invert  (alu_a_invert),
        .alu_b_invert  (alu_b_invert),
        .alu_cin       (alu_cin),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_cout      (rsp_cout),
        .rsp_ovf       (rsp_ovf),
        .rsp_err       (rsp_err),
        .rsp_count     (rsp_count)
    );

    alu8 u_alu (
        .a         (alu_src1),
        .b         (alu_src2),
        .a_invert  (alu_a_invert),
        .b_invert  (alu_b_invert),
        .cin       (alu_cin),
        .less      (alu_less),
        .operation (alu_operation),
        .result    (alu_result),
        .cout      (alu_cout)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic per op; cout for logic ops is alu8's raw adder carry.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, output logic [7:0] r, output logic c,
                                  output logic o, output logic e, output int lat);
        int ua, ub, sa, sb, t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 8'd0; c = 1'b0; o = 1'b0; e = 1'b0; lat = 2;
        case (op)
            3'd0: begin r = a & b; c = (ua + ub) > 255; end
            3'd1: begin r = a | b; c = (ua + ub) > 255; end
            3'd2: begin
                t = ua + ub + int'(cin);
                r = 8'(t);
                c = t > 255;
                o = OVF_ON && ((sa + sb + int'(cin)) > 127 || (sa + sb + int'(cin)) < -128);
            end
            3'd3: begin
                r = 8'(ua - ub);
                c = ua >= ub;
                o = OVF_ON && ((sa - sb) > 127 || (sa - sb) < -128);
            end
            3'd4: begin
                lat = 3;
                if (OVF_ON) r = (sa < sb) ? 8'd1 : 8'd0;
                else        r = (((ua - ub) & 255) >= 128) ? 8'd1 : 8'd0;
            end
            3'd5: begin r = ~(a | b); c = ((255 - ua) + (255 - ub)) > 255; end
            3'd6: begin r = ~(a & b); c = ((255 - ua) + (255 - ub)) > 255; end
            default: begin e = 1'b1; lat = 1; end
        endcase
    endfunction

    task automatic issue_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, output int lat, output logic [7:0] res,
                             output logic cout, output logic ovf, output logic err);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_cin   = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 20);
        res  = rsp_result;
        cout = rsp_cout;
        ovf  = rsp_ovf;
        err  = rsp_err;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_timeout: rsp_valid=%b required 1 within 20 cycles", rsp_valid);
        end
    endtask

    task automatic release_rsp(input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready: got %b want 0", cmd_ready);
        end
        checks++;
        if ({rsp_valid, rsp_result, rsp_cout, rsp_ovf, rsp_err, rsp_count} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got valid=%b res=%h c=%b o=%b e=%b cnt=%0d want all 0",
                     rsp_valid, rsp_result, rsp_cout, rsp_ovf, rsp_err, rsp_count);
        end
        checks++;
        if ({alu_src1, alu_src2, alu_less, alu_a_invert, alu_b_invert, alu_cin, alu_operation} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_alu: got src1=%h src2=%h less=%b ai=%b bi=%b cin=%b op=%b want all 0",
                     alu_src1, alu_src2, alu_less, alu_a_invert, alu_b_invert, alu_cin, alu_operation);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = 8'd0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] r;
        logic       c;
        logic       o;
        int         lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        int lat;
        logic [7:0] res;
        logic c, o, e;
        v[0] = '{3'b000, 8'h96, 8'hDB, 1'b0, 8'h92, 1'b1, 1'b0, 2};
        v[1] = '{3'b001, 8'h0F, 8'hA0, 1'b0, 8'hAF, 1'b0, 1'b0, 2};
        v[2] = '{3'b010, 8'h6C, 8'h91, 1'b0, 8'hFD, 1'b0, 1'b0, 2};
        v[3] = '{3'b010, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON, 2};
        v[4] = '{3'b011, 8'h34, 8'hF6, 1'b0, 8'h3E, 1'b0, 1'b0, 2};
        v[5] = '{3'b100, 8'h7F, 8'h80, 1'b0, OVF_ON ? 8'h00 : 8'h01, 1'b0, 1'b0, 3};
        v[6] = '{3'b101, 8'h0F, 8'h30, 1'b0, 8'hC0, 1'b1, 1'b0, 2};
        v[7] = '{3'b110, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 2};
        for (int i = 0; i < 8; i++) begin
            issue_cmd(v[i].op, v[i].a, v[i].b, v[i].cin, lat, res, c, o, e);
            checks++;
            if (lat != v[i].lat || res !== v[i].r || c !== v[i].c || o !== v[i].o || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_%0d op=%b: got lat=%0d res=%h c=%b o=%b e=%b want lat=%0d res=%h c=%b o=%b e=0",
                         i, v[i].op, lat, res, c, o, e, v[i].lat, v[i].r, v[i].c, v[i].o);
            end
            release_rsp(0);
            checks++;
            if (rsp_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL directed_count_%0d: got %0d want %0d", i, rsp_count, exp_count);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [7:0] res;
        logic c, o, e;
        issue_cmd(3'b100, 8'hF0, 8'h05, 1'b0, lat, res, c, o, e);
        checks++;
        if (lat != 3 || res !== 8'h01 || c !== 1'b0 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_slt: got lat=%0d res=%h c=%b e=%b want lat=3 res=01 c=0 e=0", lat, res, c, e);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 8'h01 || rsp_cout !== 1'b0 ||
                rsp_err !== 1'b0 || cmd_ready !== 1'b0 || rsp_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL hold_stable_%0d: got valid=%b res=%h c=%b e=%b ready=%b cnt=%0d want 1/01/0/0/0/%0d",
                         i, rsp_valid, rsp_result, rsp_cout, rsp_err, cmd_ready, rsp_count, exp_count);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_consume_ready: got cmd_ready=%b want 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL hold_release: got valid=%b ready=%b cnt=%0d want 0/1/%0d",
                     rsp_valid, cmd_ready, rsp_count, exp_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL hold_single_inc: got cnt=%0d want %0d", rsp_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic [7:0] res;
        logic c, o, e;
        issue_cmd(3'b010, 8'h55, 8'h22, 1'b1, lat, res, c, o, e);
        release_rsp(0);
        issue_cmd(3'b111, 8'($urandom), 8'($urandom), 1'($urandom), lat, res, c, o, e);
        checks++;
        if (lat != 1 || res !== 8'h00 || e !== 1'b1 || c !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_rsp: got lat=%0d res=%h e=%b c=%b o=%b want lat=1 res=00 e=1 c=0 o=0",
                     lat, res, e, c, o);
        end
        checks++;
        if (alu_src1 !== 8'h55 || alu_src2 !== 8'h22 || alu_operation !== 2'b10 || alu_cin !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_alu_hold: got src1=%h src2=%h op=%b cin=%b want 55/22/10/1",
                     alu_src1, alu_src2, alu_operation, alu_cin);
        end
        release_rsp(1);
        issue_cmd(3'b000, 8'h3C, 8'h0F, 1'b0, lat, res, c, o, e);
        checks++;
        if (e !== 1'b0 || res !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL illegal_err_clear: got e=%b res=%h want e=0 res=0c", e, res);
        end
        release_rsp(0);
    endtask

    task automatic test_random();
        int lat, elat;
        logic [7:0] res, er;
        logic c, o, e, ec, eo, ee;
        logic [2:0] op;
        logic [7:0] a, b;
        logic cin;
        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            model(op, a, b, cin, er, ec, eo, ee, elat);
            issue_cmd(op, a, b, cin, lat, res, c, o, e);
            checks++;
            if (lat != elat || res !== er || c !== ec || o !== eo || e !== ee) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%b a=%h b=%h cin=%b: got lat=%0d res=%h c=%b o=%b e=%b want lat=%0d res=%h c=%b o=%b e=%b",
                         i, op, a, b, cin, lat, res, c, o, e, elat, er, ec, eo, ee);
            end
            release_rsp(int'($urandom_range(0, 3)));
            checks++;
            if (rsp_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL random_count_%0d: got %0d want %0d", i, rsp_count, exp_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b100;
        cmd_a     = 8'hF0;
        cmd_b     = 8'h05;
        cmd_cin   = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = 8'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL reset_mid_%0d: got valid=%b ready=%b cnt=%0d want 0/1/%0d",
                         i, rsp_valid, cmd_ready, rsp_count, exp_count);
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [7:0] res;
        logic c, o, e;
        for (int i = 0; i < 256; i++) begin
            issue_cmd(3'b000, 8'($urandom), 8'($urandom), 1'b0, lat, res, c, o, e);
            release_rsp(0);
            if (i == 254) begin
                checks++;
                if (rsp_count !== 8'd255) begin
                    errors++;
                    $display("[TB] FAIL wrap_255: got %0d want 255", rsp_count);
                end
            end
            if (i == 255) begin
                checks++;
                if (rsp_count !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL wrap_0: got %0d want 0", rsp_count);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_illegal();
        test_random();
        test_reset();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
